// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: receives a length-prefixed, checksummed
// byte stream and writes it to instruction memory one 32-bit word at a time.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned MAX_WORDS      = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int unsigned WIDX_W = $clog2(MAX_WORDS + 1);
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [1:0]          r_bcnt, w_bcnt_nxt;
  logic [23:0]         r_shift, w_shift_nxt;
  logic [31:0]         r_nwords, w_nwords_nxt;
  logic [WIDX_W-1:0]   r_widx, w_widx_nxt;
  logic [7:0]          r_csum, w_csum_nxt;
  logic [TO_W-1:0]     r_tocnt, w_tocnt_nxt;
  logic                r_rx_ready, w_rx_ready_nxt;
  logic                r_mem_we, w_mem_we_nxt;
  logic [31:0]         r_mem_addr, w_mem_addr_nxt;
  logic [31:0]         r_mem_wr_data, w_mem_wr_data_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic                r_error, w_error_nxt;
  logic                w_accept;
  logic [31:0]         w_word;

  assign w_accept = rx_valid && r_rx_ready;
  // Bytes arrive LSB first, so the newest byte lands in the top lane.
  assign w_word   = {rx_data, r_shift};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_bcnt        <= '0;
      r_shift       <= '0;
      r_nwords      <= '0;
      r_widx        <= '0;
      r_csum        <= '0;
      r_tocnt       <= '0;
      r_rx_ready    <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= BASE_ADDR;
      r_mem_wr_data <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_bcnt        <= w_bcnt_nxt;
      r_shift       <= w_shift_nxt;
      r_nwords      <= w_nwords_nxt;
      r_widx        <= w_widx_nxt;
      r_csum        <= w_csum_nxt;
      r_tocnt       <= w_tocnt_nxt;
      r_rx_ready    <= w_rx_ready_nxt;
      r_mem_we      <= w_mem_we_nxt;
      r_mem_addr    <= w_mem_addr_nxt;
      r_mem_wr_data <= w_mem_wr_data_nxt;
      r_busy        <= w_busy_nxt;
      r_done        <= w_done_nxt;
      r_error       <= w_error_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_bcnt_nxt        = r_bcnt;
    w_shift_nxt       = r_shift;
    w_nwords_nxt      = r_nwords;
    w_widx_nxt        = r_widx;
    w_csum_nxt        = r_csum;
    w_tocnt_nxt       = r_tocnt;
    w_mem_we_nxt      = 1'b0;
    w_mem_addr_nxt    = r_mem_addr;
    w_mem_wr_data_nxt = r_mem_wr_data;

    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          w_state_nxt = S_HDR;
          w_bcnt_nxt  = '0;
          w_widx_nxt  = '0;
          w_csum_nxt  = '0;
          w_tocnt_nxt = '0;
        end
      end
      S_HDR, S_DATA, S_CSUM: begin
        if (w_accept) begin
          w_tocnt_nxt = '0;
          w_shift_nxt = w_word[31:8];
          w_bcnt_nxt  = r_bcnt + 2'd1;
          if (r_state == S_HDR && r_bcnt == 2'd3) begin
            w_nwords_nxt = w_word;
            if (w_word > 32'(MAX_WORDS))  w_state_nxt = S_ERR;
            else if (w_word == 32'd0)     w_state_nxt = S_CSUM;
            else                          w_state_nxt = S_DATA;
          end else if (r_state == S_DATA) begin
            w_csum_nxt = r_csum + rx_data;
            if (r_bcnt == 2'd3) begin
              w_mem_we_nxt      = 1'b1;
              w_mem_wr_data_nxt = w_word;
              w_mem_addr_nxt    = BASE_ADDR + (32'(r_widx) << 2);
              w_widx_nxt        = r_widx + WIDX_W'(1);
              if (32'(r_widx) + 32'd1 == r_nwords) w_state_nxt = S_CSUM;
            end
          end else if (r_state == S_CSUM) begin
            w_state_nxt = (rx_data == r_csum) ? S_DONE : S_ERR;
          end
        end else if (r_tocnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          w_state_nxt = S_ERR;
        end else begin
          w_tocnt_nxt = r_tocnt + TO_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Status outputs are registered from the next state so they track it exactly.
    w_busy_nxt     = (w_state_nxt == S_HDR) || (w_state_nxt == S_DATA) ||
                     (w_state_nxt == S_CSUM);
    w_done_nxt     = (w_state_nxt == S_DONE);
    w_error_nxt    = (w_state_nxt == S_ERR);
    w_rx_ready_nxt = w_busy_nxt && !w_mem_we_nxt;
  end

  assign rx_ready    = r_rx_ready;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wr_data = r_mem_wr_data;
  assign busy        = r_busy;
  assign done        = r_done;
  assign error       = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Directed scoreboard bench for imem_loader: expected writes are queued as
// stimulus is driven and checked as the loader strobes mem_we.
module tb_imem_loader;

  localparam int unsigned TO = 200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready, mem_we, busy, done, error;
  logic [31:0] mem_addr, mem_wr_data;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] sb[$];

  imem_loader #(.BASE_ADDR(32'h0), .MAX_WORDS(1024), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_ready(rx_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .busy(busy),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", mem_addr, 32'hFFFF_FFFF);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        chk("wr_addr", mem_addr, e[63:32]);
        chk("wr_data", mem_wr_data, e[31:0]);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit tog);
    bit ok;
    ok = 1'b0;
    if (tog) begin
      rx_valid = 1'b0;
      @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (rx_ready) begin
        @(posedge clk);
        ok = 1'b1;
      end
      @(negedge clk);
    end
    rx_valid = 1'b0;
    if (!ok) chk("byte_accept_timeout", 32'(b), 32'hFFFF_FFFF);
  endtask

  task automatic send_bytes(input logic [7:0] bs[$], input bit tog);
    foreach (bs[i]) send_byte(bs[i], tog);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end();
    for (int i = 0; i < 300 && !(done || error); i++) @(negedge clk);
    chk("end_reached", 32'(done | error), 32'd1);
  endtask

  task automatic check_status(input string tag, input logic d, input logic e);
    chk({tag, "_done"}, 32'(done), 32'(d));
    chk({tag, "_error"}, 32'(error), 32'(e));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_mem_wr_data"}, mem_wr_data, 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
  endtask

  logic [7:0] good_load[$] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                               8'h6F, 8'h00, 8'h00, 8'h00, 8'h82};

  initial begin
    #3;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Two-word image, back-to-back bytes
    sb.push_back({32'h0, 32'h0000_0013});
    sb.push_back({32'h4, 32'h0000_006F});
    do_start();
    chk("busy_after_start", 32'(busy), 32'd1);
    send_bytes(good_load, 1'b0);
    wait_end();
    check_status("load2", 1'b1, 1'b0);

    // Empty image
    do_start();
    chk("done_cleared_by_start", 32'(done), 32'd0);
    send_bytes('{8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0);
    wait_end();
    check_status("empty", 1'b1, 1'b0);

    // Word count one above capacity
    do_start();
    send_bytes('{8'h01, 8'h04, 8'h00, 8'h00}, 1'b0);
    wait_end();
    check_status("too_big", 1'b0, 1'b1);

    // Checksum mismatch: word stays written, load flagged
    sb.push_back({32'h0, 32'h0403_0201});
    do_start();
    send_bytes('{8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00}, 1'b0);
    wait_end();
    check_status("bad_csum", 1'b0, 1'b1);

    // Stream goes silent after the first of two words
    sb.push_back({32'h0, 32'h4433_2211});
    do_start();
    send_bytes('{8'h02, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44}, 1'b0);
    repeat (TO / 2) @(negedge clk);
    chk("timeout_not_early", 32'(error), 32'd0);
    chk("timeout_busy_mid", 32'(busy), 32'd1);
    wait_end();
    check_status("timeout", 1'b0, 1'b1);

    // Reset in the middle of a word, then a clean reload
    sb.push_back({32'h0, 32'h0000_0013});
    sb.push_back({32'h4, 32'h0000_006F});
    do_start();
    send_bytes('{8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB}, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_sb", 32'(sb.size()), 32'd2);
    do_start();
    send_bytes(good_load, 1'b0);
    wait_end();
    check_status("reload", 1'b1, 1'b0);

    // Same image with rx_valid toggling
    sb.push_back({32'h0, 32'h0000_0013});
    sb.push_back({32'h4, 32'h0000_006F});
    do_start();
    send_bytes(good_load, 1'b1);
    wait_end();
    check_status("toggle", 1'b1, 1'b0);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameters SHALL be: BASE_ADDR, 32'h0000_0000, byte address of the first word written; MAX_WORDS, 1024, image capacity in words (4 KiB); TIMEOUT_CYCLES, 1_000_000, maximum idle gap between bytes while loading.
REQ-002 Ports SHALL be, in order:
- clk, in, 1, single clock.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, begin a load (level sampled in IDLE/DONE/ERR).
- rx_valid, in, 1, byte available from the byte-stream source.
- rx_data, in, 8, byte value.
- rx_ready, out, 1, loader accepts a byte this cycle.
- mem_we, out, 1, one-cycle word write strobe to instruction memory.
- mem_addr, out, 32, byte address of the write (word aligned).
- mem_wr_data, out, 32, write word.
- busy, out, 1, load in progress.
- done, out, 1, last load completed and checksum matched.
- error, out, 1, last load aborted.
REQ-003 A byte SHALL be accepted exactly on a rising clk edge where rx_valid && rx_ready.

Function
REQ-004 States SHALL be IDLE, HDR, DATA, CSUM, DONE, ERR.
REQ-005 rx_ready SHALL be 1 only in HDR, DATA and CSUM, and 0 in the cycle mem_we is asserted.
REQ-006 IDLE, DONE or ERR with start=1 -> HDR; clear byte counter, word counter, checksum, timeout counter, done, error.
REQ-007 HDR: accept 4 bytes forming word count N, little-endian (first byte = bits 7:0).
REQ-008 After the 4th header byte: N > MAX_WORDS -> ERR; N == 0 -> CSUM; else -> DATA.
REQ-009 DATA: assemble each 4 accepted bytes little-endian into one word; the cycle after the 4th byte, mem_we=1 for exactly one cycle with mem_addr = BASE_ADDR + 4*i (i = 0-based word index) and mem_wr_data = assembled word.
REQ-010 Address arithmetic SHALL be 32-bit modulo 2^32; word index counter SHALL be wide enough for MAX_WORDS without wrap.
REQ-011 Checksum SHALL be the 8-bit modulo-256 sum of all data bytes (header excluded).
REQ-012 After word N-1 is written -> CSUM; accept 1 byte; equal to checksum -> DONE, else -> ERR.
REQ-013 Words already written before ERR SHALL NOT be retracted; no further mem_we after entering ERR.
REQ-014 Timeout counter SHALL reset on every accepted byte and on entry to HDR, and increment each cycle in HDR/DATA/CSUM; reaching TIMEOUT_CYCLES -> ERR.
REQ-015 busy SHALL be 1 exactly in HDR, DATA, CSUM; done SHALL be 1 exactly in DONE; error SHALL be 1 exactly in ERR.
REQ-016 start asserted while busy SHALL be ignored.
REQ-017 mem_addr and mem_wr_data SHALL hold their last values when mem_we=0.

Reset
REQ-018 rst_n=0 SHALL immediately force state IDLE, rx_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wr_data=0, busy=0, done=0, error=0, and clear all counters and checksum.
REQ-019 Reset mid-load SHALL abandon the load with no further mem_we; a partially assembled word SHALL be discarded.

Verification
REQ-020 Bench SHALL cover:
- start; bytes 02 00 00 00, 13 00 00 00, 6F 00 00 00, 82 -> writes 0x00000013 @0x0, 0x0000006F @0x4; done=1, error=0.
- start; N bytes 00 00 00 00, checksum 00 -> no mem_we; done=1.
- start; header 01 04 00 00 (N=1025) -> ERR, error=1, no mem_we.
- start; N=1, data 01 02 03 04, checksum 00 -> one write 0x04030201 @0x0; error=1, done=0.
- start; N=2, one word sent then silence for TIMEOUT_CYCLES -> one write, then error=1, busy=0.
- rst_n low after 2nd data byte, then full valid load -> all outputs at reset values, no stray write; second load completes with done=1.
- rx_valid toggling every other cycle throughout -> identical writes to the back-to-back case.
